// File: rtl/crc16_encode.sv
// USB transmit CRC16 generator: passes DATA payload bits straight through while
// stepping the LFSR, then appends the complemented 16-bit remainder MSB first.
module crc16_encode #(
  parameter logic [15:0] POLY = 16'h8005,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        empty,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_out
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] crc_q, crc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic        fb;
  logic [15:0] lfsr_step;

  assign fb        = in_bit ^ lfsr_q[15];
  assign lfsr_step = {lfsr_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= INIT;
      crc_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d = INIT;
          cnt_d  = 4'd0;
          if (empty) begin
            crc_d   = INIT;
            state_d = S_FLUSH;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (in_valid && out_ready) begin
          lfsr_d = lfsr_step;
          if (in_last) begin
            crc_d   = lfsr_step;
            cnt_d   = 4'd0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (out_ready) begin
          if (cnt_q == 4'd15) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // 15-cnt on a 4-bit counter is just its bitwise inverse.
  always_comb begin
    in_ready  = 1'b0;
    out_bit   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      S_DATA: begin
        in_ready  = out_ready;
        out_bit   = in_bit;
        out_valid = in_valid;
      end
      S_FLUSH: begin
        out_valid = 1'b1;
        out_bit   = ~crc_q[~cnt_q];
        out_last  = (cnt_q == 4'd15);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign crc_out = crc_q;

endmodule

// File: tb/tb_crc16_encode.sv
// Directed bench for crc16_encode: passthrough, appended CRC bits, receive-side
// residue, stalls, aborts by reset and back-to-back packet starts.
module tb_crc16_encode;

  logic        clock = 1'b0;
  logic        reset, start, empty, in_bit, in_valid, in_last, out_ready;
  logic        in_ready, out_bit, out_valid, out_last, busy, done;
  logic [15:0] crc_out;

  crc16_encode dut (
    .clock(clock), .reset(reset), .start(start), .empty(empty),
    .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .crc_out(crc_out)
  );

  always #5 clock = ~clock;

  int   total = 0;
  int   bad   = 0;
  bit   outq[$];
  int   last_cnt, last_pos, done_cnt, stab_err;
  bit   done_now, prev_stall, prev_bit, prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observe at the negedge (inputs and state settled), then move past the next posedge.
  task automatic cycle(output bit xfer);
    @(negedge clock);
    xfer     = in_valid && in_ready;
    done_now = done;
    if (done) done_cnt++;
    if (prev_stall && out_valid && (out_bit !== prev_bit || out_last !== prev_last)) stab_err++;
    if (out_valid && out_ready) begin
      outq.push_back(out_bit);
      if (out_last) begin last_cnt++; last_pos = outq.size(); end
    end
    prev_stall = out_valid && !out_ready;
    prev_bit   = out_bit;
    prev_last  = out_last;
    @(posedge clock); #1;
  endtask

  task automatic clear_obs();
    outq.delete();
    last_cnt = 0; last_pos = 0; done_cnt = 0; stab_err = 0; prev_stall = 0;
  endtask

  task automatic do_reset();
    bit x;
    reset = 1'b1; cycle(x); cycle(x); reset = 1'b0;
  endtask

  task automatic pulse_start(input bit e);
    bit x;
    start = 1'b1; empty = e; cycle(x); start = 1'b0; empty = 1'b0;
  endtask

  task automatic send_bits(input logic [511:0] b, input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    bit x;
    while (i < n && guard < 5000) begin
      in_bit    = b[i];
      in_last   = (i == n - 1);
      in_valid  = rnd ? ($urandom_range(3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      cycle(x);
      if (x) i++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0;
    chk("send_bound", (i == n), 1);
  endtask

  task automatic wait_done(input bit rnd);
    bit x;
    bit hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      out_ready = rnd ? ($urandom_range(1) != 0) : 1'b1;
      cycle(x);
      if (done_now) hit = 1;
    end
    out_ready = 1'b1;
    chk("done_seen", hit, 1);
  endtask

  function automatic logic [15:0] rx_residue();
    logic [15:0] l = 16'hFFFF;
    bit f;
    foreach (outq[k]) begin
      f = outq[k] ^ l[15];
      l = {l[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
    end
    return l;
  endfunction

  function automatic logic [31:0] packq();
    logic [31:0] v = '0;
    foreach (outq[k]) v = {v[30:0], outq[k]};
    return v;
  endfunction

  initial begin
    logic [511:0] rb;
    int           n;
    bit           x, ok;

    reset = 1'b1; start = 0; empty = 0; in_bit = 0; in_valid = 0; in_last = 0; out_ready = 1;
    clear_obs();
    @(posedge clock); #1;
    do_reset();

    // Reset state
    @(negedge clock);
    chk("reset_flags", {busy, out_valid, in_ready, done, out_bit, out_last}, 0);
    chk("reset_crc", crc_out, 16'h0000);
    @(posedge clock); #1;

    // Empty packet: 16 zero CRC bits, crc_out = INIT
    clear_obs();
    pulse_start(1'b1);
    wait_done(1'b0);
    chk("empty_len", outq.size(), 16);
    chk("empty_bits", packq(), 0);
    chk("empty_last", {last_cnt[7:0], last_pos[7:0]}, {8'd1, 8'd16});
    chk("empty_crc", crc_out, 16'hFFFF);
    chk("empty_done", done_cnt, 1);

    // Single 0x00 byte
    clear_obs();
    pulse_start(1'b0);
    send_bits('0, 8, 1'b0);
    wait_done(1'b0);
    chk("b00_len", outq.size(), 24);
    chk("b00_bits", packq(), 32'h0000_02FD);
    chk("b00_crc", crc_out, 16'hFD02);
    chk("b00_residue", rx_residue(), 16'h800D);

    // Random payloads with gaps and downstream stalls
    for (int p = 0; p < 3; p++) begin
      n = 8 * (p == 0 ? 1 : (p == 1 ? 64 : $urandom_range(2, 63)));
      for (int k = 0; k < 16; k++) rb[k*32 +: 32] = $urandom;
      clear_obs();
      pulse_start(1'b0);
      send_bits(rb, n, 1'b1);
      wait_done(1'b1);
      ok = (outq.size() == n + 16);
      for (int k = 0; k < n && ok; k++) if (outq[k] !== rb[k]) ok = 0;
      chk("rnd_pass", ok, 1);
      chk("rnd_residue", rx_residue(), 16'h800D);
      chk("rnd_stable", stab_err, 0);
    end

    // Stall for 5 cycles at flush_cnt==7
    clear_obs();
    pulse_start(1'b0);
    send_bits('0, 8, 1'b0);
    for (int k = 0; k < 7; k++) cycle(x);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) cycle(x);
    @(negedge clock);
    chk("stall_hold", {busy, out_valid, out_bit, out_last}, 4'b1100);
    chk("stall_cnt", outq.size(), 15);
    @(posedge clock); #1;
    wait_done(1'b0);
    chk("stall_bits", packq(), 32'h0000_02FD);
    chk("stall_len", outq.size(), 24);
    chk("stall_stable", stab_err, 0);

    // Reset mid-DATA
    clear_obs();
    pulse_start(1'b0);
    in_valid = 1; in_bit = 1;
    cycle(x); cycle(x); cycle(x);
    in_valid = 0;
    reset = 1'b1; cycle(x); reset = 1'b0;
    @(negedge clock);
    chk("rst_data", {busy, out_valid}, 0);
    @(posedge clock); #1;
    // Reset mid-FLUSH
    pulse_start(1'b1);
    cycle(x); cycle(x); cycle(x);
    reset = 1'b1; cycle(x); reset = 1'b0;
    @(negedge clock);
    chk("rst_flush", {busy, out_valid}, 0);
    @(posedge clock); #1;
    for (int k = 0; k < 20; k++) cycle(x);
    chk("rst_nodone", done_cnt, 0);
    clear_obs();
    pulse_start(1'b0);
    send_bits('0, 8, 1'b0);
    wait_done(1'b0);
    chk("rst_after_crc", crc_out, 16'hFD02);

    // start while busy is ignored
    clear_obs();
    pulse_start(1'b0);
    start = 1'b1; empty = 1'b1;
    send_bits('0, 8, 1'b0);
    start = 1'b0; empty = 1'b0;
    wait_done(1'b0);
    chk("busy_start", packq(), 32'h0000_02FD);
    chk("busy_len", outq.size(), 24);

    // start in the done cycle begins a fresh packet with no lost bits
    clear_obs();
    pulse_start(1'b1);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      ok = out_valid && out_ready && out_last;
      @(posedge clock); #1;
    end
    start = 1'b1; empty = 1'b0;
    @(negedge clock);
    chk("dn_done", {done, busy}, 2'b10);
    @(posedge clock); #1;
    start = 1'b0;
    clear_obs();
    send_bits('0, 8, 1'b0);
    wait_done(1'b0);
    chk("dn_bits", packq(), 32'h0000_02FD);
    chk("dn_crc", crc_out, 16'hFD02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
